heightmap_pixel_writer: RTL and testbench



---
 rtl/heightmap_pixel_writer.sv | 237 +++++++++++++++++++++++
 tb/tb_heightmap_pixel_writer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heightmap_pixel_writer.sv
// -----------------------------------------------------------------------------
// heightmap_pixel_writer
//
// Pulls every (x,y,z) sample out of the diamond-square generator once it
// reports done, maps each height to an RGB332 terrain colour and paints the
// sample as a CELL x CELL pixel square into the VGA pixel buffer through an
// Avalon-MM write master. Raises frame_done after DIM*DIM samples.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-low reset
//   done_in          generator done flag; samples available while high
//   x_in, y_in       generator sample column / row (10 bits)
//   z_in             generator sample height (8 bits)
//   bus_ack          one-cycle pulse requesting the next sample
//   bus_addr         Avalon byte write address
//   bus_write        Avalon write strobe
//   bus_writedata    RGB332 pixel
//   bus_waitrequest  Avalon stall
//   busy             high in every state except IDLE and DONE
//   frame_done       high in DONE
// -----------------------------------------------------------------------------
module heightmap_pixel_writer #(
    parameter int unsigned DIM       = 9,
    parameter int unsigned CELL_LOG2 = 5,
    parameter logic [31:0] X0        = 32'd16,
    parameter logic [31:0] Y0        = 32'd16,
    parameter logic [31:0] PIX_BASE  = 32'hC800_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done_in,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic [7:0]  z_in,
    output logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [7:0]  bus_writedata,
    input  logic        bus_waitrequest,
    output logic        busy,
    output logic        frame_done
);

    // Sample counter must hold DIM*DIM.
    localparam int unsigned CW = 2 * $clog2(DIM) + 1;
    // One spare bit so the sub-pixel counters are never zero-width.
    localparam int unsigned IW = CELL_LOG2 + 1;

    localparam logic [IW-1:0] CELL_LAST = IW'((1 << CELL_LOG2) - 1);
    localparam logic [CW-1:0] TOTAL     = CW'(DIM * DIM);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACK,
        S_W1,
        S_W2,
        S_W3,
        S_LATCH,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [9:0]      x_q;
    logic [9:0]      y_q;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   j_q;
    logic            ack_q;
    logic            write_q;
    logic [31:0]     addr_q;
    logic [7:0]      data_q;

    logic [IW-1:0]   i_d;
    logic [IW-1:0]   j_d;
    logic [CW-1:0]   cnt_d;
    logic [31:0]     addr_d;
    logic            last_beat;
    logic            beat_done;

    // Byte address of pixel (X0 + x*CELL + i, Y0 + y*CELL + j); 1024-byte rows.
    function automatic logic [31:0] pix_addr(input logic [9:0]    x,
                                             input logic [9:0]    y,
                                             input logic [IW-1:0] i,
                                             input logic [IW-1:0] j);
        logic [31:0] px;
        logic [31:0] py;
        px = X0 + ({22'd0, x} << CELL_LOG2) + 32'(i);
        py = Y0 + ({22'd0, y} << CELL_LOG2) + 32'(j);
        return PIX_BASE + (py << 10) + px;
    endfunction

    function automatic logic [7:0] terrain_colour(input logic [7:0] z);
        logic [7:0] c;
        if (z < 8'd64)       c = 8'h03;   // water
        else if (z < 8'd96)  c = 8'hF8;   // sand
        else if (z < 8'd160) c = 8'h1C;   // grass
        else if (z < 8'd224) c = 8'h92;   // rock
        else                 c = 8'hFF;   // snow
        return c;
    endfunction

    // Next sub-pixel: i runs fastest, wrapping into j.
    always_comb begin
        i_d       = i_q + 1'b1;
        j_d       = j_q;
        if (i_q == CELL_LAST) begin
            i_d = '0;
            j_d = j_q + 1'b1;
        end
        last_beat = (i_q == CELL_LAST) && (j_q == CELL_LAST);
        beat_done = write_q && !bus_waitrequest;
        addr_d    = pix_addr(x_q, y_q, i_d, j_d);
        cnt_d     = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ack_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (done_in) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                    end
                end

                S_ACK: begin
                    ack_q <= 1'b0;
                    if (!done_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_W1;
                    end
                end

                S_W1, S_W2, S_W3: begin
                    if (!done_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        case (state_q)
                            S_W1:    state_q <= S_W2;
                            S_W2:    state_q <= S_W3;
                            default: state_q <= S_LATCH;
                        endcase
                    end
                end

                S_LATCH: begin
                    if (!done_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        i_q     <= '0;
                        j_q     <= '0;
                        data_q  <= terrain_colour(z_in);
                        addr_q  <= pix_addr(x_in, y_in, '0, '0);
                        write_q <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end

                // Address, data and strobe only move on a completed beat,
                // so a stalled beat is held and an abort waits for it.
                S_WRITE: begin
                    if (beat_done) begin
                        if (!done_in) begin
                            write_q <= 1'b0;
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else if (last_beat) begin
                            write_q <= 1'b0;
                            state_q <= S_NEXT;
                        end else begin
                            i_q    <= i_d;
                            j_q    <= j_d;
                            addr_q <= addr_d;
                        end
                    end
                end

                S_NEXT: begin
                    if (!done_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TOTAL) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (!done_in) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ack_q   <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_ack       = ack_q;
    assign bus_write     = write_q;
    assign bus_addr      = addr_q;
    assign bus_writedata = data_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_heightmap_pixel_writer.sv
module tb_heightmap_pixel_writer;

    localparam logic [31:0] BASE = 32'hC800_0000;

    logic        clk;
    logic        reset;
    logic        done_in;
    logic [9:0]  x_in;
    logic [9:0]  y_in;
    logic [7:0]  z_in;
    logic        bus_ack;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [7:0]  bus_writedata;
    logic        bus_waitrequest;
    logic        busy;
    logic        frame_done;

    heightmap_pixel_writer #(
        .DIM       (9),
        .CELL_LOG2 (1),
        .X0        (32'd16),
        .Y0        (32'd16),
        .PIX_BASE  (32'hC800_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .done_in         (done_in),
        .x_in            (x_in),
        .y_in            (y_in),
        .z_in            (z_in),
        .bus_ack         (bus_ack),
        .bus_addr        (bus_addr),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_waitrequest (bus_waitrequest),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [31:0] log_addr[$];
    logic [7:0]  log_data[$];

    int   ack_cnt, beat_cnt, inv_viol;
    int   stall_viol, stall_cycles, stall_left, stall_beat;
    bit   force_wr, prev_ack;
    int   gen_k, gen_pend_k, gen_dly;
    logic [31:0] cap_addr;
    logic [7:0]  cap_data;

    function automatic logic [7:0] ztab(input int k);
        case (k)
            0: return 8'd63;
            1: return 8'd64;
            2: return 8'd95;
            3: return 8'd96;
            4: return 8'd159;
            5: return 8'd160;
            6: return 8'd223;
            7: return 8'd224;
            29: return 8'd100;
            default: return 8'((k * 53 + 7) % 256);
        endcase
    endfunction

    function automatic logic [7:0] colour_ref(input logic [7:0] z);
        if (z <= 8'd63)  return 8'h03;
        if (z <= 8'd95)  return 8'hF8;
        if (z <= 8'd159) return 8'h1C;
        if (z <= 8'd223) return 8'h92;
        return 8'hFF;
    endfunction

    function automatic logic [7:0] sweep_colour(input int k);
        case (k)
            0: return 8'h03;
            1: return 8'hF8;
            2: return 8'hF8;
            3: return 8'h1C;
            4: return 8'h1C;
            5: return 8'h92;
            6: return 8'h92;
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: everything is sampled and driven on the falling edge.
    task automatic step();
        int px, py;
        @(negedge clk);
        if (force_wr) begin
            bus_waitrequest = 1'b1;
        end else if (stall_left > 0) begin
            bus_waitrequest = 1'b1;
            stall_left--;
            stall_cycles++;
            if (bus_write !== 1'b1 || bus_addr !== cap_addr ||
                bus_writedata !== cap_data || bus_ack !== 1'b0)
                stall_viol++;
        end else if (stall_beat >= 0 && bus_write === 1'b1 && beat_cnt == stall_beat) begin
            bus_waitrequest = 1'b1;
            cap_addr     = bus_addr;
            cap_data     = bus_writedata;
            stall_cycles = 1;
            stall_left   = 4;
            stall_beat   = -1;
        end else begin
            bus_waitrequest = 1'b0;
        end

        if (bus_write === 1'b1 && bus_waitrequest === 1'b0) begin
            beat_cnt++;
            log_addr.push_back(bus_addr);
            log_data.push_back(bus_writedata);
            tests++;
            if (exp_addr_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got addr=%h data=%h, required no beat", bus_addr, bus_writedata);
            end else begin
                logic [31:0] ea;
                logic [7:0]  ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (bus_addr !== ea || bus_writedata !== ed) begin
                    fails++;
                    $display("FAIL beat_%0d: got addr=%h data=%h, required addr=%h data=%h",
                             beat_cnt - 1, bus_addr, bus_writedata, ea, ed);
                end
            end
        end

        if (bus_ack === 1'b1 && (bus_write === 1'b1 || prev_ack)) inv_viol++;
        prev_ack = (bus_ack === 1'b1);

        // Generator model: data valid three edges after the ack cycle.
        if (bus_ack === 1'b1) begin
            ack_cnt++;
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < 2; i++) begin
                    px = 16 + 2 * (gen_k % 9) + i;
                    py = 16 + 2 * (gen_k / 9) + j;
                    exp_addr_q.push_back(BASE + 32'(py * 1024 + px));
                    exp_data_q.push_back(colour_ref(ztab(gen_k)));
                end
            end
            gen_pend_k = gen_k;
            gen_k++;
            gen_dly = 3;
            x_in = 10'h3FF;
            y_in = 10'h3FF;
            z_in = 8'h00;
        end else if (gen_dly > 0) begin
            gen_dly--;
            if (gen_dly == 0) begin
                x_in = 10'(gen_pend_k % 9);
                y_in = 10'(gen_pend_k / 9);
                z_in = ztab(gen_pend_k);
            end
        end
    endtask

    task automatic start_frame();
        exp_addr_q.delete();
        exp_data_q.delete();
        log_addr.delete();
        log_data.delete();
        ack_cnt = 0; beat_cnt = 0; inv_viol = 0;
        stall_viol = 0; stall_cycles = 0; stall_left = 0; stall_beat = -1;
        force_wr = 1'b0;
        gen_k = 0; gen_dly = 0;
        done_in = 1'b1;
    endtask

    task automatic run_frame(input string name, input int stall_at);
        start_frame();
        stall_beat = stall_at;
        for (int n = 0; n < 3000 && frame_done !== 1'b1; n++) step();
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: frame_done=%b, required 1 within 3000 cycles", name, frame_done);
        end
        tests++;
        if (ack_cnt != 81 || beat_cnt != 324) begin
            fails++;
            $display("FAIL %s_counts: acks=%0d writes=%0d, required 81 and 324", name, ack_cnt, beat_cnt);
        end
        tests++;
        if (exp_addr_q.size() != 0 || inv_viol != 0) begin
            fails++;
            $display("FAIL %s_leftover: pending=%0d ack_violations=%0d, required 0 and 0",
                     name, exp_addr_q.size(), inv_viol);
        end
        repeat (10) step();
        tests++;
        if (ack_cnt != 81 || beat_cnt != 324 || frame_done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_hold: acks=%0d writes=%0d frame_done=%b busy=%b, required 81 324 1 0",
                     name, ack_cnt, beat_cnt, frame_done, busy);
        end
        done_in = 1'b0;
        step();
        tests++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_release: frame_done=%b busy=%b, required 0 0", name, frame_done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; done_in = 1'b0; bus_waitrequest = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        prev_ack = 1'b0; force_wr = 1'b0; stall_left = 0; stall_beat = -1; gen_dly = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus_ack, bus_write, busy, frame_done} !== 4'b0 || bus_addr !== 32'h0 || bus_writedata !== 8'h0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b wr=%b busy=%b fd=%b addr=%h data=%h, required all 0",
                     bus_ack, bus_write, busy, frame_done, bus_addr, bus_writedata);
        end
        reset = 1'b1;
        repeat (4) step();
        tests++;
        if (bus_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: ack=%b busy=%b, required 0 0 with done_in low", bus_ack, busy);
        end
    endtask

    task automatic test_cell_address();
        logic [31:0] req;
        tests++;
        if (log_addr.size() < 120) begin
            fails++;
            $display("FAIL cell_log_size: got %0d beats, required at least 120", log_addr.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                case (b)
                    0: req = 32'hC800_0000 + 32'd22 * 32'd1024 + 32'd20;
                    1: req = 32'hC800_0000 + 32'd22 * 32'd1024 + 32'd21;
                    2: req = 32'hC800_0000 + 32'd23 * 32'd1024 + 32'd20;
                    default: req = 32'hC800_0000 + 32'd23 * 32'd1024 + 32'd21;
                endcase
                tests++;
                if (log_addr[116 + b] !== req || log_data[116 + b] !== 8'h1C) begin
                    fails++;
                    $display("FAIL cell_x2y3_beat%0d: got addr=%h data=%h, required addr=%h data=1c",
                             b, log_addr[116 + b], log_data[116 + b], req);
                end
            end
        end
    endtask

    task automatic test_colour_sweep();
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (log_data.size() < 32 || log_data[4 * k] !== sweep_colour(k)) begin
                fails++;
                $display("FAIL colour_z%0d: got %h, required %h", ztab(k),
                         (log_data.size() < 32) ? 8'hxx : log_data[4 * k], sweep_colour(k));
            end
        end
    endtask

    task automatic test_stall();
        run_frame("stall", 1);
        tests++;
        if (stall_cycles != 5 || stall_viol != 0) begin
            fails++;
            $display("FAIL stall_hold: stall_cycles=%0d unstable_cycles=%0d, required 5 and 0",
                     stall_cycles, stall_viol);
        end
    endtask

    task automatic test_drop_in_w2();
        start_frame();
        for (int n = 0; n < 2000 && ack_cnt < 31; n++) step();
        step();
        step();
        tests++;
        if (busy !== 1'b1 || ack_cnt != 31) begin
            fails++;
            $display("FAIL drop_reach_w2: busy=%b acks=%0d, required 1 and 31", busy, ack_cnt);
        end
        done_in = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || bus_ack !== 1'b0 || bus_write !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL drop_to_idle: busy=%b ack=%b wr=%b fd=%b, required 0 0 0 0",
                     busy, bus_ack, bus_write, frame_done);
        end
        tests++;
        if (exp_addr_q.size() != 4) begin
            fails++;
            $display("FAIL drop_pending: got %0d pending beats, required 4", exp_addr_q.size());
        end
        repeat (3) step();
        run_frame("after_drop", -1);
    endtask

    task automatic test_reset_mid_write();
        start_frame();
        for (int n = 0; n < 2000 && !(ack_cnt >= 40 && bus_write === 1'b1); n++) step();
        force_wr = 1'b1;
        step();
        tests++;
        if (bus_write !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_setup: bus_write=%b, required 1 during stall", bus_write);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({bus_ack, bus_write, busy, frame_done} !== 4'b0 || bus_addr !== 32'h0 || bus_writedata !== 8'h0) begin
            fails++;
            $display("FAIL rst_mid_async: ack=%b wr=%b busy=%b fd=%b addr=%h data=%h, required all 0",
                     bus_ack, bus_write, busy, frame_done, bus_addr, bus_writedata);
        end
        force_wr = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        gen_dly = 0;
        step();
        reset = 1'b1;
        run_frame("after_reset", -1);
    endtask

    initial begin
        test_reset();
        run_frame("frame", -1);
        test_cell_address();
        test_colour_sweep();
        test_stall();
        test_drop_in_w2();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
